// File: rtl/bus_ext_mailbox.sv
// Multi-channel CPU/external mailbox: per channel an RX FIFO (external -> CPU) and a TX FIFO
// (CPU -> external), a memory-mapped register window and a level interrupt.
module bus_ext_mailbox #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_9000,
    parameter int                    NUM_CHANNELS = 2,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [ADDR_WIDTH-1:0]              address_i,
    input  logic                               we_i,
    input  logic                               re_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               irq_o,
    input  logic [NUM_CHANNELS-1:0]            ext_wr_valid_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ext_wr_data_i,
    output logic [NUM_CHANNELS-1:0]            ext_wr_ready_o,
    output logic [NUM_CHANNELS-1:0]            ext_rd_valid_o,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] ext_rd_data_o,
    input  logic [NUM_CHANNELS-1:0]            ext_rd_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [ADDR_WIDTH-1:0] WIN_SIZE = ADDR_WIDTH'(NUM_CHANNELS * 16);
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    logic [DATA_WIDTH-1:0] rx_mem_r [NUM_CHANNELS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_r [NUM_CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]      rx_wr_ptr_r [NUM_CHANNELS];
    logic [PTR_W-1:0]      rx_rd_ptr_r [NUM_CHANNELS];
    logic [PTR_W-1:0]      tx_wr_ptr_r [NUM_CHANNELS];
    logic [PTR_W-1:0]      tx_rd_ptr_r [NUM_CHANNELS];
    logic [CNT_W-1:0]      rx_cnt_r    [NUM_CHANNELS];
    logic [CNT_W-1:0]      tx_cnt_r    [NUM_CHANNELS];
    logic [1:0]            irq_en_r    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] tx_ovf_r;
    logic [NUM_CHANNELS-1:0] rx_udf_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  irq_r;

    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  hit_s;
    logic [CH_W-1:0]       ch_s;
    logic [1:0]            reg_s;
    logic [NUM_CHANNELS-1:0] sel_s;
    logic [NUM_CHANNELS-1:0] rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic [NUM_CHANNELS-1:0] rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic [NUM_CHANNELS-1:0] rx_udf_set_s, tx_ovf_set_s;
    logic [NUM_CHANNELS-1:0] flush_rx_s, flush_tx_s, clr_sticky_s, en_wr_s, irq_src_s;
    logic [DATA_WIDTH-1:0] rd_mux_s;
    logic [DATA_WIDTH-1:0] status_s;

    // Unaligned or out-of-window accesses fall outside every channel.
    assign offset_s = address_i - BASE_ADDR;
    assign hit_s    = (address_i >= BASE_ADDR) && (offset_s < WIN_SIZE) && (offset_s[1:0] == 2'b00);
    assign ch_s     = offset_s[4 +: CH_W];
    assign reg_s    = offset_s[3:2];

    // Per-channel FIFO status, handshakes and CPU access events.
    always_comb begin
        sel_s        = {NUM_CHANNELS{1'b0}};
        rx_empty_s   = {NUM_CHANNELS{1'b0}};
        rx_full_s    = {NUM_CHANNELS{1'b0}};
        tx_empty_s   = {NUM_CHANNELS{1'b0}};
        tx_full_s    = {NUM_CHANNELS{1'b0}};
        rx_push_s    = {NUM_CHANNELS{1'b0}};
        rx_pop_s     = {NUM_CHANNELS{1'b0}};
        tx_push_s    = {NUM_CHANNELS{1'b0}};
        tx_pop_s     = {NUM_CHANNELS{1'b0}};
        rx_udf_set_s = {NUM_CHANNELS{1'b0}};
        tx_ovf_set_s = {NUM_CHANNELS{1'b0}};
        flush_rx_s   = {NUM_CHANNELS{1'b0}};
        flush_tx_s   = {NUM_CHANNELS{1'b0}};
        clr_sticky_s = {NUM_CHANNELS{1'b0}};
        en_wr_s      = {NUM_CHANNELS{1'b0}};
        irq_src_s    = {NUM_CHANNELS{1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sel_s[c]      = hit_s && (ch_s == CH_W'(c));
            rx_empty_s[c] = (rx_cnt_r[c] == CNT_W'(0));
            rx_full_s[c]  = (rx_cnt_r[c] == CNT_W'(FIFO_DEPTH));
            tx_empty_s[c] = (tx_cnt_r[c] == CNT_W'(0));
            tx_full_s[c]  = (tx_cnt_r[c] == CNT_W'(FIFO_DEPTH));
            rx_pop_s[c]     = re_i && sel_s[c] && (reg_s == REG_DATA) && !rx_empty_s[c];
            rx_udf_set_s[c] = re_i && sel_s[c] && (reg_s == REG_DATA) && rx_empty_s[c];
            // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
            rx_push_s[c]    = ext_wr_valid_i[c] && (!rx_full_s[c] || rx_pop_s[c]);
            tx_pop_s[c]     = ext_rd_ready_i[c] && !tx_empty_s[c];
            tx_push_s[c]    = we_i && sel_s[c] && (reg_s == REG_DATA) && (!tx_full_s[c] || tx_pop_s[c]);
            tx_ovf_set_s[c] = we_i && sel_s[c] && (reg_s == REG_DATA) && tx_full_s[c] && !tx_pop_s[c];
            flush_rx_s[c]   = we_i && sel_s[c] && (reg_s == REG_CTRL) && data_i[0];
            flush_tx_s[c]   = we_i && sel_s[c] && (reg_s == REG_CTRL) && data_i[1];
            clr_sticky_s[c] = we_i && sel_s[c] && (reg_s == REG_CTRL) && data_i[2];
            en_wr_s[c]      = we_i && sel_s[c] && (reg_s == REG_IRQ_EN);
            irq_src_s[c]    = (!rx_empty_s[c] && irq_en_r[c][0]) || (tx_empty_s[c] && irq_en_r[c][1]);
        end
    end

    // FIFO storage; contents are only observable through valid pointers, so no reset.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rx_push_s[c]) begin
                rx_mem_r[c][rx_wr_ptr_r[c]] <= ext_wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (tx_push_s[c]) begin
                tx_mem_r[c][tx_wr_ptr_r[c]] <= data_i;
            end
        end
    end

    // Pointers, counts, sticky flags and interrupt enables; flush overrides push and pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rx_wr_ptr_r[c] <= {PTR_W{1'b0}};
                rx_rd_ptr_r[c] <= {PTR_W{1'b0}};
                tx_wr_ptr_r[c] <= {PTR_W{1'b0}};
                tx_rd_ptr_r[c] <= {PTR_W{1'b0}};
                rx_cnt_r[c]    <= {CNT_W{1'b0}};
                tx_cnt_r[c]    <= {CNT_W{1'b0}};
                irq_en_r[c]    <= 2'b00;
            end
            tx_ovf_r <= {NUM_CHANNELS{1'b0}};
            rx_udf_r <= {NUM_CHANNELS{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (flush_rx_s[c]) begin
                    rx_wr_ptr_r[c] <= {PTR_W{1'b0}};
                    rx_rd_ptr_r[c] <= {PTR_W{1'b0}};
                    rx_cnt_r[c]    <= {CNT_W{1'b0}};
                end else begin
                    if (rx_push_s[c]) rx_wr_ptr_r[c] <= rx_wr_ptr_r[c] + PTR_W'(1);
                    if (rx_pop_s[c])  rx_rd_ptr_r[c] <= rx_rd_ptr_r[c] + PTR_W'(1);
                    case ({rx_push_s[c], rx_pop_s[c]})
                        2'b10:   rx_cnt_r[c] <= rx_cnt_r[c] + CNT_W'(1);
                        2'b01:   rx_cnt_r[c] <= rx_cnt_r[c] - CNT_W'(1);
                        default: rx_cnt_r[c] <= rx_cnt_r[c];
                    endcase
                end
                if (flush_tx_s[c]) begin
                    tx_wr_ptr_r[c] <= {PTR_W{1'b0}};
                    tx_rd_ptr_r[c] <= {PTR_W{1'b0}};
                    tx_cnt_r[c]    <= {CNT_W{1'b0}};
                end else begin
                    if (tx_push_s[c]) tx_wr_ptr_r[c] <= tx_wr_ptr_r[c] + PTR_W'(1);
                    if (tx_pop_s[c])  tx_rd_ptr_r[c] <= tx_rd_ptr_r[c] + PTR_W'(1);
                    case ({tx_push_s[c], tx_pop_s[c]})
                        2'b10:   tx_cnt_r[c] <= tx_cnt_r[c] + CNT_W'(1);
                        2'b01:   tx_cnt_r[c] <= tx_cnt_r[c] - CNT_W'(1);
                        default: tx_cnt_r[c] <= tx_cnt_r[c];
                    endcase
                end
                if (en_wr_s[c]) irq_en_r[c] <= data_i[1:0];
                // A new error event in the clearing cycle is kept rather than lost.
                tx_ovf_r[c] <= (tx_ovf_r[c] && !clr_sticky_s[c]) || tx_ovf_set_s[c];
                rx_udf_r[c] <= (rx_udf_r[c] && !clr_sticky_s[c]) || rx_udf_set_s[c];
            end
        end
    end

    // CPU read mux for the addressed channel register.
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        status_s = {DATA_WIDTH{1'b0}};
        if (hit_s) begin
            status_s[0]     = !rx_empty_s[ch_s];
            status_s[1]     = rx_full_s[ch_s];
            status_s[2]     = tx_empty_s[ch_s];
            status_s[3]     = tx_full_s[ch_s];
            status_s[4]     = tx_ovf_r[ch_s];
            status_s[5]     = rx_udf_r[ch_s];
            status_s[15:8]  = 8'(rx_cnt_r[ch_s]);
            status_s[23:16] = 8'(tx_cnt_r[ch_s]);
            case (reg_s)
                REG_DATA:   rd_mux_s = rx_empty_s[ch_s] ? {DATA_WIDTH{1'b0}} : rx_mem_r[ch_s][rx_rd_ptr_r[ch_s]];
                REG_STATUS: rd_mux_s = status_s;
                REG_IRQ_EN: rd_mux_s = {{(DATA_WIDTH-2){1'b0}}, irq_en_r[ch_s]};
                REG_CTRL:   rd_mux_s = {DATA_WIDTH{1'b0}};
                default:    rd_mux_s = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            rd_mux_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Registered read data (held between reads) and registered interrupt.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r <= {DATA_WIDTH{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            if (re_i) data_r <= rd_mux_s;
            irq_r <= |irq_src_s;
        end
    end

    // External stream outputs; the head word is masked while the TX FIFO is empty.
    always_comb begin
        ext_rd_data_o = {(NUM_CHANNELS*DATA_WIDTH){1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (tx_empty_s[c]) begin
                ext_rd_data_o[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else begin
                ext_rd_data_o[c*DATA_WIDTH +: DATA_WIDTH] = tx_mem_r[c][tx_rd_ptr_r[c]];
            end
        end
    end

    assign ext_wr_ready_o = ~rx_full_s;
    assign ext_rd_valid_o = ~tx_empty_s;
    assign data_o         = data_r;
    assign irq_o          = irq_r;

endmodule

// File: tb/tb_bus_ext_mailbox.sv
// Self-checking bench for bus_ext_mailbox: register vector table, queue models of the
// RX/TX FIFOs and hand-written multi-cycle sequences.
module tb_bus_ext_mailbox;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] address_i;
    logic        we_i;
    logic        re_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq_o;
    logic [1:0]  ext_wr_valid_i;
    logic [63:0] ext_wr_data_i;
    logic [1:0]  ext_wr_ready_o;
    logic [1:0]  ext_rd_valid_o;
    logic [63:0] ext_rd_data_o;
    logic [1:0]  ext_rd_ready_i;

    bus_ext_mailbox dut (
        .clk_i(clk_i), .reset_i(reset_i), .address_i(address_i), .we_i(we_i), .re_i(re_i),
        .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
        .ext_wr_valid_i(ext_wr_valid_i), .ext_wr_data_i(ext_wr_data_i), .ext_wr_ready_o(ext_wr_ready_o),
        .ext_rd_valid_o(ext_rd_valid_o), .ext_rd_data_o(ext_rd_data_o), .ext_rd_ready_i(ext_rd_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] rx_q0[$];
    logic [31:0] rx_q1[$];
    logic [31:0] tx_q0[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        address_i = a; data_i = d; we_i = 1'b1;
        @(negedge clk_i);
        we_i = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk_i);
        address_i = a; re_i = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk_i);
        re_i = 1'b0;
        check(name, data_o, sb_q.pop_front());
    endtask

    function automatic logic [31:0] rx_model_pop(input int ch);
        logic [31:0] v;
        v = 32'h0;
        if (ch == 0) begin
            if (rx_q0.size() > 0) v = rx_q0.pop_front();
        end else begin
            if (rx_q1.size() > 0) v = rx_q1.pop_front();
        end
        return v;
    endfunction

    task automatic ext_push(input int ch, input logic [31:0] d);
        int n;
        @(negedge clk_i);
        ext_wr_valid_i[ch] = 1'b1;
        ext_wr_data_i[ch*32 +: 32] = d;
        n = 0;
        while (!ext_wr_ready_o[ch] && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!ext_wr_ready_o[ch]) begin
            checks++; errors++;
            $display("FAIL push_timeout ch%0d ready=0 required=1", ch);
            ext_wr_valid_i[ch] = 1'b0;
        end else begin
            @(negedge clk_i);
            ext_wr_valid_i[ch] = 1'b0;
            if (ch == 0) rx_q0.push_back(d); else rx_q1.push_back(d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_9004, 32'h0, 32'h0000_0004, "st0_reset"};
        vecs[1]  = '{1'b0, 32'h0000_9014, 32'h0, 32'h0000_0004, "st1_reset"};
        vecs[2]  = '{1'b0, 32'h0000_9008, 32'h0, 32'h0000_0000, "irqen0_reset"};
        vecs[3]  = '{1'b1, 32'h0000_9018, 32'hFFFF_FFFF, 32'h0, "irqen1_wr"};
        vecs[4]  = '{1'b0, 32'h0000_9018, 32'h0, 32'h0000_0003, "irqen1_readback"};
        vecs[5]  = '{1'b1, 32'h0000_9018, 32'h0000_0000, 32'h0, "irqen1_clr"};
        vecs[6]  = '{1'b0, 32'h0000_9018, 32'h0, 32'h0000_0000, "irqen1_zero"};
        vecs[7]  = '{1'b0, 32'h0000_900C, 32'h0, 32'h0000_0000, "ctrl_reads0"};
        vecs[8]  = '{1'b1, 32'h0000_9020, 32'h0000_DEAD, 32'h0, "unmapped_wr"};
        vecs[9]  = '{1'b0, 32'h0000_9020, 32'h0, 32'h0000_0000, "unmapped_hi"};
        vecs[10] = '{1'b0, 32'h0000_8FFC, 32'h0, 32'h0000_0000, "unmapped_lo"};
        vecs[11] = '{1'b0, 32'h0000_9006, 32'h0, 32'h0000_0000, "unaligned"};

        reset_i = 1'b1; address_i = 32'h0; we_i = 1'b0; re_i = 1'b0; data_i = 32'h0;
        ext_wr_valid_i = 2'b00; ext_wr_data_i = 64'h0; ext_rd_ready_i = 2'b00;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("reset_data_o", data_o, 32'h0);
        check("reset_irq", 32'(irq_o), 32'h0);
        check("reset_wr_ready", 32'(ext_wr_ready_o), 32'h3);
        check("reset_rd_valid", 32'(ext_rd_valid_o), 32'h0);
        check("reset_rd_data", 32'(|ext_rd_data_o), 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdata);
            else            cpu_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        cpu_read(32'h0000_9004, 32'h0000_0004, "st0_after_unmapped");
        @(negedge clk_i);
        check("irq_idle", 32'(irq_o), 32'h0);

        // RX ch1 fill to full, blocked 5th push, drain with one underflow.
        ext_push(1, 32'hA1); ext_push(1, 32'hA2); ext_push(1, 32'hA3);
        check("ch1_ready_3", 32'(ext_wr_ready_o[1]), 32'h1);
        ext_push(1, 32'hA4);
        check("ch1_ready_full", 32'(ext_wr_ready_o[1]), 32'h0);
        ext_wr_valid_i[1] = 1'b1; ext_wr_data_i[63:32] = 32'hA5;
        repeat (3) begin
            @(negedge clk_i);
            check("ch1_held_off", 32'(ext_wr_ready_o[1]), 32'h0);
        end
        ext_wr_valid_i[1] = 1'b0;
        cpu_read(32'h0000_9014, 32'h0000_0407, "ch1_status_full");
        for (int i = 0; i < 5; i++) cpu_read(32'h0000_9010, rx_model_pop(1), "ch1_rx_data");
        cpu_read(32'h0000_9014, 32'h0000_0024, "ch1_underflow");
        cpu_write(32'h0000_901C, 32'h0000_0004);
        cpu_read(32'h0000_9014, 32'h0000_0004, "ch1_sticky_clr");

        // TX ch0 overflow, then external drain one word per cycle.
        for (int i = 0; i < 5; i++) begin
            cpu_write(32'h0000_9000, 32'h11 + 32'(i));
            if (tx_q0.size() < 4) tx_q0.push_back(32'h11 + 32'(i));
        end
        cpu_read(32'h0000_9004, 32'h0004_0018, "ch0_tx_overflow");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("tx_valid", 32'(ext_rd_valid_o[0]), 32'h1);
            check("tx_data", ext_rd_data_o[31:0], tx_q0.pop_front());
            ext_rd_ready_i[0] = 1'b1;
        end
        @(negedge clk_i);
        ext_rd_ready_i[0] = 1'b0;
        check("tx_drained", 32'(ext_rd_valid_o[0]), 32'h0);
        cpu_read(32'h0000_9004, 32'h0000_0014, "ch0_tx_empty_ovf");
        cpu_write(32'h0000_900C, 32'h0000_0004);

        // Full RX ch0 with CPU pop and external push in the same cycle.
        ext_push(0, 32'hB1); ext_push(0, 32'hB2); ext_push(0, 32'hB3); ext_push(0, 32'hB4);
        @(negedge clk_i);
        check("sim_ready_pre", 32'(ext_wr_ready_o[0]), 32'h0);
        address_i = 32'h0000_9000; re_i = 1'b1;
        ext_wr_valid_i[0] = 1'b1; ext_wr_data_i[31:0] = 32'hB5;
        sb_q.push_back(rx_model_pop(0));
        rx_q0.push_back(32'hB5);
        @(negedge clk_i);
        re_i = 1'b0; ext_wr_valid_i[0] = 1'b0;
        check("sim_pop_data", data_o, sb_q.pop_front());
        check("sim_ready", 32'(ext_wr_ready_o[0]), 32'h0);
        cpu_read(32'h0000_9004, 32'h0000_0407, "sim_status");
        for (int i = 0; i < 4; i++) cpu_read(32'h0000_9000, rx_model_pop(0), "sim_order");
        cpu_read(32'h0000_9004, 32'h0000_0004, "sim_empty");

        // IRQ on rx_nonempty, cleared by flush.
        cpu_write(32'h0000_9008, 32'h0000_0001);
        @(negedge clk_i);
        check("irq_en_no_src", 32'(irq_o), 32'h0);
        @(negedge clk_i);
        ext_wr_valid_i[0] = 1'b1; ext_wr_data_i[31:0] = 32'hC1;
        @(negedge clk_i);
        ext_wr_valid_i[0] = 1'b0;
        check("irq_not_yet", 32'(irq_o), 32'h0);
        @(negedge clk_i);
        check("irq_asserted", 32'(irq_o), 32'h1);
        cpu_write(32'h0000_900C, 32'h0000_0001);
        check("irq_still_on", 32'(irq_o), 32'h1);
        @(negedge clk_i);
        check("irq_after_flush", 32'(irq_o), 32'h0);

        // Flush and push in the same cycle: flush wins.
        @(negedge clk_i);
        address_i = 32'h0000_900C; data_i = 32'h1; we_i = 1'b1;
        ext_wr_valid_i[0] = 1'b1; ext_wr_data_i[31:0] = 32'hD1;
        @(negedge clk_i);
        we_i = 1'b0; ext_wr_valid_i[0] = 1'b0;
        @(negedge clk_i);
        check("flush_push_irq", 32'(irq_o), 32'h0);
        cpu_read(32'h0000_9004, 32'h0000_0004, "flush_beats_push");

        // tx_empty interrupt source on ch1.
        cpu_write(32'h0000_9018, 32'h0000_0002);
        @(negedge clk_i);
        check("irq_tx_empty", 32'(irq_o), 32'h1);
        cpu_write(32'h0000_9018, 32'h0000_0000);
        @(negedge clk_i);
        check("irq_tx_empty_off", 32'(irq_o), 32'h0);

        // Reset mid-transfer discards everything.
        ext_push(1, 32'hE1);
        cpu_write(32'h0000_9010, 32'hE2);
        check("pre_rst_valid", 32'(ext_rd_valid_o[1]), 32'h1);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        rx_q0.delete(); rx_q1.delete(); tx_q0.delete();
        check("rst_rd_valid", 32'(ext_rd_valid_o), 32'h0);
        check("rst_rd_data", 32'(|ext_rd_data_o), 32'h0);
        check("rst_wr_ready", 32'(ext_wr_ready_o), 32'h3);
        cpu_read(32'h0000_9014, 32'h0000_0004, "rst_status_ch1");
        cpu_read(32'h0000_9008, 32'h0000_0000, "rst_irqen_ch0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
